// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, LSU load response, load-issue tracking and
// the register-file write port, grouped so the arbiter and its users share one definition.
interface wb_arbiter_if #(
    parameter int addr_w = 5,
    parameter int data_w = 32
);
    logic                   alu_valid;
    logic                   alu_ready;
    logic [addr_w-1:0]      alu_rd;
    logic [data_w-1:0]      alu_data;

    logic                   lsu_valid;
    logic                   lsu_ready;
    logic [addr_w-1:0]      lsu_rd;
    logic [data_w-1:0]      lsu_data;
    logic [2:0]             lsu_funct3;
    logic [1:0]             lsu_offset;

    logic                   ld_issue;
    logic [addr_w-1:0]      ld_issue_rd;
    logic [2**addr_w-1:0]   busy;

    logic                   wr_en;
    logic [addr_w-1:0]      wr_addr;
    logic [data_w-1:0]      wr_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_offset,
        input  ld_issue, ld_issue_rd,
        output alu_ready, lsu_ready, busy, wr_en, wr_addr, wr_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, lsu_funct3, lsu_offset,
        output ld_issue, ld_issue_rd,
        input  alu_ready, lsu_ready, busy, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and extended load data through a 2-entry
// load FIFO onto one registered register-file write port, and tracks pending loads.
module wb_arbiter #(
    parameter int addr_w = 5,
    parameter int data_w = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int NREG = 2**addr_w;

    logic [1:0]        fifoCnt_q, fifoCnt_d;
    logic [addr_w-1:0] entRd_q   [2];
    logic [addr_w-1:0] entRd_d   [2];
    logic [data_w-1:0] entData_q [2];
    logic [data_w-1:0] entData_d [2];

    logic              wrEn_q, wrEn_d;
    logic [addr_w-1:0] wrAddr_q, wrAddr_d;
    logic [data_w-1:0] wrData_q, wrData_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              fifoFull;
    logic              aluFire;
    logic              lsuFire;
    logic              popFire;
    logic [data_w-1:0] lsuExt;

    function automatic logic [data_w-1:0] extendLoad(
        input logic [2:0]        f3,
        input logic [1:0]        off,
        input logic [data_w-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(data_w-8){b[7]}}, b};
            3'b100:  return {{(data_w-8){1'b0}}, b};
            3'b001:  return {{(data_w-16){h[15]}}, h};
            3'b101:  return {{(data_w-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    // A full FIFO always drains first; otherwise the ALU has priority over queued loads.
    assign fifoFull      = (fifoCnt_q == 2'd2);
    assign bus.alu_ready = !fifoFull;
    assign bus.lsu_ready = !fifoFull;
    assign aluFire       = bus.alu_valid && !fifoFull;
    assign lsuFire       = bus.lsu_valid && !fifoFull;
    assign popFire       = fifoFull || (!bus.alu_valid && (fifoCnt_q != 2'd0));
    assign lsuExt        = extendLoad(bus.lsu_funct3, bus.lsu_offset, bus.lsu_data);

    always_comb begin
        fifoCnt_d = fifoCnt_q;
        entRd_d   = entRd_q;
        entData_d = entData_q;
        if (popFire) begin
            entRd_d[0]   = entRd_q[1];
            entData_d[0] = entData_q[1];
            fifoCnt_d    = fifoCnt_q - 2'd1;
        end
        if (lsuFire) begin
            entRd_d[fifoCnt_d[0]]   = bus.lsu_rd;
            entData_d[fifoCnt_d[0]] = lsuExt;
            fifoCnt_d               = fifoCnt_d + 2'd1;
        end
    end

    // Scoreboard set is applied after the pop clear so a same-cycle reissue stays busy.
    always_comb begin
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        busy_d   = busy_q;
        if (aluFire) begin
            wrEn_d   = (bus.alu_rd != '0);
            wrAddr_d = bus.alu_rd;
            wrData_d = bus.alu_data;
        end else if (popFire) begin
            wrEn_d             = (entRd_q[0] != '0);
            wrAddr_d           = entRd_q[0];
            wrData_d           = entData_q[0];
            busy_d[entRd_q[0]] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_rd != '0)) begin
            busy_d[bus.ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifoCnt_q    <= 2'd0;
            entRd_q[0]   <= '0;
            entRd_q[1]   <= '0;
            entData_q[0] <= '0;
            entData_q[1] <= '0;
            wrEn_q       <= 1'b0;
            wrAddr_q     <= '0;
            wrData_q     <= '0;
            busy_q       <= '0;
        end else begin
            fifoCnt_q    <= fifoCnt_d;
            entRd_q      <= entRd_d;
            entData_q    <= entData_d;
            wrEn_q       <= wrEn_d;
            wrAddr_q     <= wrAddr_d;
            wrData_q     <= wrData_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.wr_en   = wrEn_q;
    assign bus.wr_addr = wrAddr_q;
    assign bus.wr_data = wrData_q;
    assign bus.busy    = busy_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; drives its single write port.
- Merges single-cycle ALU results and out-of-order-in-time load responses from the LSU onto one registered write port.
- Performs load byte/halfword extraction and sign/zero extension.
- Keeps a pending-load scoreboard so issue logic can stall on RAW/WAW hazards against outstanding loads.

Parameters:
- addr_w, 5, register address width; scoreboard has 2**addr_w bits.
- data_w, 32, register data width; the load extraction logic is defined for 32 only.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- alu_valid  input  1  ALU result present
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  addr_w  ALU destination register
- alu_data  input  data_w  ALU result
- lsu_valid  input  1  load response present
- lsu_ready  output  1  load response accepted this cycle
- lsu_rd  input  addr_w  load destination register
- lsu_data  input  data_w  raw aligned memory word
- lsu_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- lsu_offset  input  2  byte address bits [1:0]
- ld_issue  input  1  a load is being issued this cycle
- ld_issue_rd  input  addr_w  destination of issued load
- busy  output  2**addr_w  bit n set = load to xn outstanding
- wr_en  output  1  register file write enable
- wr_addr  output  addr_w  register file write address
- wr_data  output  data_w  register file write data

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, busy=all 0, load FIFO empty. lsu_ready=1 and alu_ready=1 in the first cycle after reset.
- Load FIFO:
  - 2 entries; each stores rd and the already-extended data.
  - Extension is done on entry.
  - LB/LBU select byte lsu_offset. LH/LHU select halfword lsu_offset[1]; lsu_offset[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Undefined funct3 values (011, 110, 111) behave as LW.
- Handshakes: transfer occurs when valid&ready. Ready is combinational from internal state only, never from valid.
  - lsu_ready = FIFO not full. A push and a pop in the same cycle on a full FIFO is not permitted, so lsu_ready=0 when full.
  - alu_ready = FIFO count < 2.
- Arbitration, evaluated each cycle:
  - FIFO count == 2: pop the FIFO head; alu_ready=0.
  - Otherwise, if alu_valid: the ALU wins; the FIFO holds.
  - Otherwise, if the FIFO is non-empty: pop the head.
  - Otherwise: no write.
- Load bypass: the load path never writes directly. Every load enters the FIFO first, so a load written back has ≥2 cycles latency from acceptance.
- Write port:
  - The winner is registered; wr_* are valid in the cycle after selection (1-cycle latency).
  - wr_en=0 whenever the selected rd==0; wr_addr/wr_data still update.
  - When there is no winner, wr_en=0 and wr_addr/wr_data hold their previous values.
- Scoreboard:
  - ld_issue with ld_issue_rd≠0 sets busy[ld_issue_rd] at the next edge.
  - A FIFO pop clears busy[rd] at the same edge wr_en is registered.
  - Simultaneous set and clear of the same bit: set wins.
  - busy[0] is constant 0.
  - Issue logic guarantees no ld_issue to an already-busy rd; the block does not check this.
- ALU ordering: the ALU result is never written while a load to the same rd is pending. Issue logic stalls on busy; the block does not check this.
- Reset mid-operation discards FIFO contents and clears busy in one cycle, with no write issued in the following cycle.

Test Plan:
- Reset then idle: no valid inputs for 5 cycles -> wr_en=0, busy=0, alu_ready=lsu_ready=1 throughout.
- ALU result: alu_valid, rd=3, data=0xDEADBEEF -> next cycle wr_en=1, wr_addr=3, wr_data=0xDEADBEEF. Repeat with rd=0 -> wr_en=0.
- Load extension, each with rd=5 and lsu_data=0x8081F2F3:
  - LB offset 1 -> 0xFFFFFFF2
  - LBU offset 3 -> 0x00000080
  - LH offset 2 -> 0xFFFF8081
  - LHU offset 0 -> 0x0000F2F3
  - LW -> 0x8081F2F3
- Contention: alu_valid held high continuously while two loads arrive (rd=6, rd=7):
  - After the second push, alu_ready=0 and lsu_ready=0.
  - The rd=6 write occurs, then alu_ready returns to 1 (count=1).
  - The ALU then wins over rd=7 until the FIFO refills or the ALU idles.
  - The rd=7 write occurs when alu_valid drops.
- Scoreboard: ld_issue rd=9 -> busy[9]=1 next cycle; load response rd=9 accepted -> busy[9] clears the same edge wr_en rises. A same-cycle issue of rd=9 while rd=9 pops -> busy[9] stays 1.
- Reset mid-operation: FIFO holds 2 entries and busy[4]=1, rst pulsed for 1 cycle -> next cycle busy=0, wr_en=0, lsu_ready=1; no stale write follows.
